// File: rtl/receiver_pkg.sv
// rtl/receiver_pkg.sv - shared reply codes, result and state types for the pulse-link app layer
package skyfi_app_pkg;

  // Reply bytes sent back to the peer transmitter.
  localparam logic [7:0] ACK_CODE  = 8'h06;
  localparam logic [7:0] NACK_CODE = 8'h15;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_DECODE,
    ERR_OVERFLOW,
    ERR_ENC_TMO
  } rx_err_t;

  typedef enum logic [2:0] {
    WAIT_RX,
    CONSUME,
    SEND,
    ENC_BUSY,
    ENC_DONE
  } rx_state_t;

  // Only a clean packet is acknowledged; every failure class gets a NACK.
  function automatic logic [7:0] reply_code(rx_err_t cls);
    return (cls == ERR_NONE) ? ACK_CODE : NACK_CODE;
  endfunction

endpackage

// File: rtl/receiver_if.sv
// rtl/receiver_if.sv - Decoder/Encoder handshake bundle seen by the receiver
interface receiver_if #(
  parameter int N_PKT = 8
);

  logic [N_PKT-1:0] data_DEC;
  logic             avail_DEC;
  logic             error_DEC;
  logic             read_DEC;
  logic [N_PKT-1:0] data_ENC;
  logic             start_ENC;
  logic             avail_ENC;

  // Link side: the Decoder/Encoder pair.
  modport master (
    output data_DEC, avail_DEC, error_DEC, avail_ENC,
    input  read_DEC, data_ENC, start_ENC
  );

  // Receiver side.
  modport slave (
    input  data_DEC, avail_DEC, error_DEC, avail_ENC,
    output read_DEC, data_ENC, start_ENC
  );

endinterface

// File: rtl/receiver_sat_counter.sv
// rtl/receiver_sat_counter.sv - event counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] q
);

  // Count up on inc, hold once every bit is set so the value never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/receiver.sv
// rtl/receiver.sv - receive-node responder: latch good packets, ACK/NACK every packet
module receiver
  import skyfi_app_pkg::*;
#(
  parameter int N_PKT       = 8,
  parameter int ENC_TIMEOUT = 1_000_000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             avail,
  output rx_err_t          err_code,
  output logic [N_PKT-1:0] data_out,
  output logic             data_valid,
  input  logic             data_read,
  receiver_if.slave        link,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] bad_count
);

  // The count only has to reach ENC_TIMEOUT-1 before the FSM bails out.
  localparam int TMO_W = (ENC_TIMEOUT < 2) ? 1 : $clog2(ENC_TIMEOUT);

  rx_state_t        state;
  rx_state_t        state_nxt;
  rx_err_t          cls;
  rx_err_t          cls_now;
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_reply;
  logic             tmo_hit;
  logic             reply_done;
  logic             inc_good;
  logic             inc_bad;

  assign in_reply = (state == SEND) || (state == ENC_BUSY) || (state == ENC_DONE);
  assign tmo_hit  = in_reply && (tmo_cnt == TMO_W'(ENC_TIMEOUT - 1));
  assign inc_good = (state == CONSUME) && (cls_now == ERR_NONE);
  assign inc_bad  = (state == CONSUME) && (cls_now != ERR_NONE);

  // The reply byte is only presented while a reply is in flight.
  assign link.data_ENC = in_reply ? N_PKT'(reply_code(cls)) : '0;

  // Classify the packet on offer; a same-cycle data_read frees the buffer.
  always_comb begin
    cls_now = ERR_NONE;
    if (link.error_DEC) begin
      cls_now = ERR_DECODE;
    end else if (data_valid && !data_read) begin
      cls_now = ERR_OVERFLOW;
    end
  end

  // Next-state and handshake strobes; the reply timeout overrides any progress.
  always_comb begin
    state_nxt      = state;
    avail          = 1'b0;
    link.read_DEC  = 1'b0;
    link.start_ENC = 1'b0;
    reply_done     = 1'b0;
    case (state)
      WAIT_RX: begin
        avail = 1'b1;
        if (start && link.avail_DEC) state_nxt = CONSUME;
      end
      CONSUME: begin
        link.read_DEC = 1'b1;
        state_nxt     = SEND;
      end
      SEND: begin
        if (tmo_hit) begin
          state_nxt = WAIT_RX;
        end else if (link.avail_ENC) begin
          link.start_ENC = 1'b1;
          state_nxt      = ENC_BUSY;
        end
      end
      ENC_BUSY: begin
        if (tmo_hit) state_nxt = WAIT_RX;
        else if (!link.avail_ENC) state_nxt = ENC_DONE;
      end
      ENC_DONE: begin
        if (tmo_hit) begin
          state_nxt = WAIT_RX;
        end else if (link.avail_ENC) begin
          reply_done = 1'b1;
          state_nxt  = WAIT_RX;
        end
      end
      default: state_nxt = WAIT_RX;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_RX;
    else        state <= state_nxt;
  end

  // Cycles spent waiting on the Encoder, restarted for every packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tmo_cnt <= '0;
    else if (state == CONSUME) tmo_cnt <= '0;
    else if (in_reply)         tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // Hold the packet class for the reply byte and the final result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cls <= ERR_NONE;
    else if (state == CONSUME) cls <= cls_now;
  end

  // Publish the result only once the reply has finished or been abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err_code <= ERR_NONE;
    else if (tmo_hit)    err_code <= ERR_ENC_TMO;
    else if (reply_done) err_code <= cls;
  end

  // One-entry app buffer: a new good packet beats a concurrent read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (inc_good) begin
      data_out   <= link.data_DEC;
      data_valid <= 1'b1;
    end else if (data_read) begin
      data_valid <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_good_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_good),
    .clear (1'b0),
    .q     (good_count)
  );

  sat_counter #(.W(CNT_W)) u_bad_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_bad),
    .clear (1'b0),
    .q     (bad_count)
  );

endmodule

// File: tb/tb_receiver.sv
// tb/tb_receiver.sv - directed bench for receiver with a transaction-level model
module tb_receiver;
  import skyfi_app_pkg::*;

  localparam int N_PKT = 8;
  localparam int TMO   = 100;
  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          data_read = 1'b0;
  logic          avail;
  logic          data_valid;
  rx_err_t       err_code;
  logic [7:0]    data_out;
  logic [CW-1:0] good_count;
  logic [CW-1:0] bad_count;

  receiver_if #(.N_PKT(N_PKT)) link ();

  receiver #(.N_PKT(N_PKT), .ENC_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .avail      (avail),
    .err_code   (err_code),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_read  (data_read),
    .link       (link.slave),
    .good_count (good_count),
    .bad_count  (bad_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model of the app-visible state, updated per packet.
  logic [7:0] m_data = 8'h00;
  bit         m_valid = 1'b0;
  int         m_good = 0;
  int         m_bad = 0;
  rx_err_t    m_err = ERR_NONE;
  bit         chk_en = 1'b0;

  // Encoder model.
  int         enc_busy_len = 3;
  bit         enc_stall = 1'b0;
  int         n_start = 0;
  logic [7:0] replies[$];

  initial begin
    int busy;
    busy = 0;
    link.avail_ENC = 1'b1;
    forever begin
      @(negedge clk);
      if (link.start_ENC === 1'b1) begin
        n_start++;
        replies.push_back(link.data_ENC);
        busy = enc_busy_len;
      end
      @(posedge clk);
      #1;
      if (busy > 0) begin
        link.avail_ENC = 1'b0;
        busy--;
      end else begin
        link.avail_ENC = !enc_stall;
      end
    end
  end

  // Idle-state comparison against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("idle_avail", avail, 1'b1);
      check("idle_data_out", data_out, m_data);
      check("idle_data_valid", data_valid, m_valid);
      check("idle_good_count", good_count, m_good);
      check("idle_bad_count", bad_count, m_bad);
      check("idle_err_code", err_code, m_err);
      check("idle_data_ENC", link.data_ENC, 8'h00);
      check("idle_read_DEC", link.read_DEC, 1'b0);
      check("idle_start_ENC", link.start_ENC, 1'b0);
    end
  end

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Offer one packet, complete the reply, and check it against the model.
  task automatic send_pkt(input logic [7:0] d, input bit e, input bit rd_same,
                          input bit exp_tmo, input bit drop_start,
                          output logic [7:0] got_reply, output int cyc);
    rx_err_t    c;
    logic [7:0] exp_reply;
    int         n;
    chk_en = 1'b0;
    got_reply = 8'hxx;
    if (e)                      c = ERR_DECODE;
    else if (m_valid && !rd_same) c = ERR_OVERFLOW;
    else                        c = ERR_NONE;
    exp_reply = (c == ERR_NONE) ? 8'h06 : 8'h15;
    link.data_DEC  = d;
    link.error_DEC = e;
    link.avail_DEC = 1'b1;
    @(posedge clk); #1;
    check("read_DEC_latency", link.read_DEC, 1'b1);
    if (rd_same) data_read = 1'b1;
    @(posedge clk); #1;
    link.avail_DEC = 1'b0;
    link.error_DEC = 1'b0;
    data_read = 1'b0;
    if (drop_start) start = 1'b0;
    if (c == ERR_NONE) begin
      m_data  = d;
      m_valid = 1'b1;
      m_good  = sat_inc(m_good);
    end else begin
      m_bad = sat_inc(m_bad);
      if (rd_same) m_valid = 1'b0;
    end
    check("read_DEC_pulse", link.read_DEC, 1'b0);
    check("consume_data_valid", data_valid, m_valid);
    check("consume_data_out", data_out, m_data);
    check("send_data_ENC", link.data_ENC, exp_reply);
    n = 0;
    while (!avail && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    cyc = n;
    if (!avail) check("avail_wait_expired", avail, 1'b1);
    m_err = exp_tmo ? ERR_ENC_TMO : c;
    if (!exp_tmo) begin
      if (replies.size() > 0) begin
        got_reply = replies.pop_front();
        check("reply_byte", got_reply, exp_reply);
      end else begin
        check("reply_missing", 1'b0, 1'b1);
      end
    end
    chk_en = 1'b1;
  endtask

  // Pulse data_read for one cycle while idle.
  task automatic app_read();
    chk_en = 1'b0;
    data_read = 1'b1;
    @(posedge clk); #1;
    data_read = 1'b0;
    m_valid = 1'b0;
    chk_en = 1'b1;
  endtask

  // With start low, a waiting packet must be left alone.
  task automatic hold_off_check(input string tag);
    link.data_DEC  = 8'hEE;
    link.avail_DEC = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check({tag, "_read_DEC"}, link.read_DEC, 1'b0);
      check({tag, "_avail"}, avail, 1'b1);
    end
    link.avail_DEC = 1'b0;
  endtask

  initial begin
    logic [7:0] rep;
    int         cyc;
    int         n;
    int         s0;
    link.data_DEC  = '0;
    link.avail_DEC = 1'b0;
    link.error_DEC = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_avail", avail, 1'b1);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_err_code", err_code, ERR_NONE);
    check("rst_good", good_count, 0);
    check("rst_bad", bad_count, 0);
    check("rst_read_DEC", link.read_DEC, 1'b0);
    check("rst_start_ENC", link.start_ENC, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    hold_off_check("start_low");
    start = 1'b1;

    // 1: good packet
    send_pkt(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, rep, cyc);
    check("t1_reply", rep, 8'h06);
    check("t1_data_out", data_out, 8'h3C);
    check("t1_data_valid", data_valid, 1'b1);
    check("t1_good", good_count, 1);
    check("t1_err", err_code, ERR_NONE);

    app_read();
    check("read_clears_valid", data_valid, 1'b0);
    app_read();
    check("read_when_empty", data_valid, 1'b0);

    // 2: decode error
    send_pkt(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, rep, cyc);
    check("t2_reply", rep, 8'h15);
    check("t2_err", err_code, ERR_DECODE);
    check("t2_bad", bad_count, 1);
    check("t2_data_valid", data_valid, 1'b0);

    // 3: overflow on the second unread packet
    send_pkt(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, rep, cyc);
    send_pkt(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, rep, cyc);
    check("t3_reply", rep, 8'h15);
    check("t3_data_out", data_out, 8'h11);
    check("t3_err", err_code, ERR_OVERFLOW);
    check("t3_bad", bad_count, 2);

    // 4: read coincident with the new latch
    send_pkt(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, rep, cyc);
    check("t4_reply", rep, 8'h06);
    check("t4_data_out", data_out, 8'h22);
    check("t4_data_valid", data_valid, 1'b1);
    check("t4_err", err_code, ERR_NONE);

    // start dropped mid-transaction: reply finishes, then no new packets
    send_pkt(8'h33, 1'b0, 1'b1, 1'b0, 1'b1, rep, cyc);
    check("drop_start_reply", rep, 8'h06);
    hold_off_check("drop_start");
    start = 1'b1;

    // bad_count saturation
    for (int i = 0; i < 6; i++) send_pkt(8'(i), 1'b1, 1'b0, 1'b0, 1'b0, rep, cyc);
    check("bad_saturates", bad_count, CMAX);

    // 5: Encoder never idle -> timeout
    enc_stall = 1'b1;
    @(posedge clk); #1;
    s0 = n_start;
    send_pkt(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, rep, cyc);
    check("t5_cycles", cyc, TMO);
    check("t5_no_start_ENC", n_start, s0);
    check("t5_err", err_code, ERR_ENC_TMO);
    enc_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 6: reset during ENC_BUSY
    chk_en = 1'b0;
    enc_busy_len = 20;
    link.data_DEC  = 8'h77;
    link.avail_DEC = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    link.avail_DEC = 1'b0;
    n = 0;
    while (link.avail_ENC && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_enc_busy_reached", link.avail_ENC, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_avail", avail, 1'b1);
    check("t6_start_ENC", link.start_ENC, 1'b0);
    check("t6_read_DEC", link.read_DEC, 1'b0);
    check("t6_good", good_count, 0);
    check("t6_bad", bad_count, 0);
    check("t6_data_valid", data_valid, 1'b0);
    check("t6_data_ENC", link.data_ENC, 8'h00);
    #2;
    rst_n = 1'b1;
    m_data = 8'h00; m_valid = 1'b0; m_good = 0; m_bad = 0; m_err = ERR_NONE;
    replies.delete();
    enc_busy_len = 3;
    n = 0;
    while (!link.avail_ENC && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk_en = 1'b1;
    send_pkt(8'h99, 1'b0, 1'b0, 1'b0, 1'b0, rep, cyc);
    check("t6_new_reply", rep, 8'h06);
    check("t6_new_data_out", data_out, 8'h99);
    check("t6_new_good", good_count, 1);

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
